// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues single-outstanding ibus requests, fills the IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN adds a fetch_misalign output and traps on misaligned PCs.
module fetch_stage #(
    parameter logic [63:0] PC_INIT = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_misalign,
`endif
    output logic [96:0] dataF
);

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;

    typedef enum logic [1:0] {FETCH, HOLD, DROP, TRAP} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    fetch_data_t if_id, if_id_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [63:0] skid_pc, skid_pc_next;
    logic        skid_valid, skid_valid_next;
    logic [63:0] tgt, tgt_next;
    logic        req;
    logic        free;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign, misalign_next;
    logic        misaligned;

    assign misaligned     = (pc[1:0] != 2'b00);
    assign fetch_misalign = misalign;
    assign ireq_addr      = pc;
`else
    assign ireq_addr      = {pc[63:2], 2'b00};
`endif

    assign free       = !if_id.valid || !stall;
    // Reset gates the request combinationally so the bus sees it drop at once.
    assign ireq_valid = reset && req;
    assign dataF      = if_id;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        if_id_next      = if_id;
        skid_instr_next = skid_instr;
        skid_pc_next    = skid_pc;
        skid_valid_next = skid_valid;
        tgt_next        = tgt;
        req             = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_next   = misalign;
`endif
        case (state)
            FETCH: begin
                req = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (misaligned) begin
                    req = 1'b0;
                    if (redirect_valid) begin
                        pc_next          = redirect_pc;
                        if_id_next.valid = 1'b0;
                    end else if (free) begin
                        if_id_next.raw_instr = '0;
                        if_id_next.pc        = pc;
                        if_id_next.valid     = 1'b1;
                        misalign_next        = 1'b1;
                        state_next           = TRAP;
                    end
                end else
`endif
                if (redirect_valid && iresp_data_ok) begin
                    pc_next          = redirect_pc;
                    if_id_next.valid = 1'b0;
                end else if (redirect_valid) begin
                    tgt_next         = redirect_pc;
                    if_id_next.valid = 1'b0;
                    state_next       = DROP;
                end else if (iresp_data_ok && free) begin
                    if_id_next.raw_instr = iresp_data;
                    if_id_next.pc        = pc;
                    if_id_next.valid     = 1'b1;
                    pc_next              = pc + 64'd4;
                end else if (iresp_data_ok) begin
                    skid_instr_next = iresp_data;
                    skid_pc_next    = pc;
                    skid_valid_next = 1'b1;
                    pc_next         = pc + 64'd4;
                    state_next      = HOLD;
                end else if (!stall) begin
                    if_id_next.valid = 1'b0;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    skid_valid_next  = 1'b0;
                    if_id_next.valid = 1'b0;
                    pc_next          = redirect_pc;
                    state_next       = FETCH;
                end else if (!stall) begin
                    if_id_next.raw_instr = skid_instr;
                    if_id_next.pc        = skid_pc;
                    if_id_next.valid     = skid_valid;
                    skid_valid_next      = 1'b0;
                    state_next           = FETCH;
                end
            end
            DROP: begin
                // Old address stays on the bus until its response retires.
                req = 1'b1;
                if (redirect_valid) begin
                    tgt_next         = redirect_pc;
                    if_id_next.valid = 1'b0;
                end
                if (iresp_data_ok) begin
                    pc_next    = redirect_valid ? redirect_pc : tgt;
                    state_next = FETCH;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: begin
                if (redirect_valid) begin
                    pc_next          = redirect_pc;
                    if_id_next.valid = 1'b0;
                    misalign_next    = 1'b0;
                    state_next       = FETCH;
                end else if (!stall) begin
                    if_id_next.valid = 1'b0;
                    misalign_next    = 1'b0;
                end
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            if_id      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
            tgt        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            if_id      <= if_id_next;
            skid_instr <= skid_instr_next;
            skid_pc    <= skid_pc_next;
            skid_valid <= skid_valid_next;
            tgt        <= tgt_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign   <= misalign_next;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, skid hold, redirects in each state, reset, PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [96:0] dataF;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int tests;
    int errors;

    fetch_stage #(.PC_INIT(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .dataF          (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic ok, input logic [31:0] d, input logic stl,
                       input logic rv, input logic [63:0] rpc);
        iresp_data_ok  = ok;
        iresp_data     = d;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] raw);
        check({tag, ".valid"}, 64'(dataF[0]), 64'(v));
        if (v) begin
            check({tag, ".pc"},  dataF[64:1], pc);
            check({tag, ".raw"}, 64'(dataF[96:65]), 64'(raw));
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [63:0] addr);
        check({tag, ".ireq_valid"}, 64'(ireq_valid), 64'(v));
        if (v) check({tag, ".ireq_addr"}, ireq_addr, addr);
    endtask

    localparam logic [31:0] I0  = 32'h0010_0093;
    localparam logic [31:0] I1  = 32'h0020_0113;
    localparam logic [31:0] I2  = 32'h0030_0193;
    localparam logic [31:0] I3  = 32'h0040_0213;
    localparam logic [31:0] I4  = 32'h0050_0293;
    localparam logic [31:0] I5  = 32'h0060_0313;
    localparam logic [31:0] I6  = 32'h0070_0393;
    localparam logic [31:0] I7  = 32'h0080_0413;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        tests          = 0;
        errors         = 0;
        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        #12;
        check("rst.ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst.dataF_lo",   dataF[63:0], 64'd0);
        check("rst.dataF_hi",   64'(dataF[96:64]), 64'd0);
        reset = 1'b1;
        #1;
        chk_req("rel", 1'b1, 64'h8000_0000);

        // streaming, one instruction per edge
        cyc(1'b1, I0, 1'b0, 1'b0, '0);
        chk_out("s0", 1'b1, 64'h8000_0000, I0);
        chk_req("s0", 1'b1, 64'h8000_0004);
        cyc(1'b1, I1, 1'b0, 1'b0, '0);
        chk_out("s1", 1'b1, 64'h8000_0004, I1);
        cyc(1'b1, I2, 1'b0, 1'b0, '0);
        chk_out("s2", 1'b1, 64'h8000_0008, I2);
        chk_req("s2", 1'b1, 64'h8000_000c);

        // response arrives under stall -> skid, HOLD
        cyc(1'b1, I3, 1'b1, 1'b0, '0);
        chk_out("h0", 1'b1, 64'h8000_0008, I2);
        chk_req("h0", 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        chk_out("h1", 1'b1, 64'h8000_0008, I2);
        chk_req("h1", 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        chk_out("h2", 1'b1, 64'h8000_0008, I2);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        chk_out("h3", 1'b1, 64'h8000_000c, I3);
        chk_req("h3", 1'b1, 64'h8000_0010);

        // redirect while request pending -> DROP
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
        chk_out("d0", 1'b0, '0, '0);
        chk_req("d0", 1'b1, 64'h8000_0010);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        chk_out("d1", 1'b0, '0, '0);
        chk_req("d1", 1'b1, 64'h8000_0010);
        cyc(1'b1, BAD, 1'b0, 1'b0, '0);
        chk_out("d2", 1'b0, '0, '0);
        chk_req("d2", 1'b1, 64'h8000_0100);

        // redirect with data_ok and stall in the same cycle
        cyc(1'b1, I4, 1'b0, 1'b0, '0);
        chk_out("r0", 1'b1, 64'h8000_0100, I4);
        cyc(1'b1, BAD, 1'b1, 1'b1, 64'h8000_0180);
        chk_out("r1", 1'b0, '0, '0);
        chk_req("r1", 1'b1, 64'h8000_0180);
        cyc(1'b1, I5, 1'b0, 1'b0, '0);
        chk_out("r2", 1'b1, 64'h8000_0180, I5);
        chk_req("r2", 1'b1, 64'h8000_0184);

        // two redirects in DROP, latest wins
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0200);
        chk_req("m0", 1'b1, 64'h8000_0184);
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0300);
        chk_req("m1", 1'b1, 64'h8000_0184);
        cyc(1'b1, BAD, 1'b0, 1'b0, '0);
        chk_out("m2", 1'b0, '0, '0);
        chk_req("m2", 1'b1, 64'h8000_0300);
        cyc(1'b1, I6, 1'b0, 1'b0, '0);
        chk_out("m3", 1'b1, 64'h8000_0300, I6);

        // redirect coinciding with the DROP response
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0400);
        chk_req("m4", 1'b1, 64'h8000_0304);
        cyc(1'b1, BAD, 1'b0, 1'b1, 64'h8000_0500);
        chk_out("m5", 1'b0, '0, '0);
        chk_req("m5", 1'b1, 64'h8000_0500);

        // redirect while in HOLD drops the skid
        cyc(1'b1, I7, 1'b0, 1'b0, '0);
        chk_out("k0", 1'b1, 64'h8000_0500, I7);
        cyc(1'b1, 32'h1111_1111, 1'b1, 1'b0, '0);
        chk_req("k1", 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b1, 64'h8000_0600);
        chk_out("k2", 1'b0, '0, '0);
        chk_req("k2", 1'b1, 64'h8000_0600);
        cyc(1'b1, I0, 1'b0, 1'b0, '0);
        chk_out("k3", 1'b1, 64'h8000_0600, I0);

        // PC wraps modulo 2^64
        cyc(1'b1, BAD, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_req("w0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b1, I1, 1'b0, 1'b0, '0);
        chk_out("w1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, I1);
        chk_req("w1", 1'b1, 64'h0);

        // reset asserted mid-DROP
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0700);
        chk_req("x0", 1'b1, 64'h0);
        reset = 1'b0;
        #1;
        check("x1.ireq_valid", 64'(ireq_valid), 64'd0);
        check("x1.valid", 64'(dataF[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_req("x2", 1'b1, 64'h8000_0000);
        check("x2.valid", 64'(dataF[0]), 64'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
        cyc(1'b1, BAD, 1'b0, 1'b1, 64'h8000_0102);
        check("t0.ireq_valid", 64'(ireq_valid), 64'd0);
        check("t0.misalign", 64'(fetch_misalign), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("t1.misalign", 64'(fetch_misalign), 64'd1);
        chk_out("t1", 1'b1, 64'h8000_0102, 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("t2.misalign", 64'(fetch_misalign), 64'd1);
        chk_out("t2", 1'b1, 64'h8000_0102, 32'h0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        check("t3.misalign", 64'(fetch_misalign), 64'd0);
        check("t3.valid", 64'(dataF[0]), 64'd0);
        check("t3.ireq_valid", 64'(ireq_valid), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 64'h8000_0800);
        chk_req("t4", 1'b1, 64'h8000_0800);
`else
        cyc(1'b1, BAD, 1'b0, 1'b1, 64'h8000_0102);
        chk_req("a0", 1'b1, 64'h8000_0100);
        cyc(1'b1, I2, 1'b0, 1'b0, '0);
        chk_out("a1", 1'b1, 64'h8000_0102, I2);
        chk_req("a1", 1'b1, 64'h8000_0104);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
